multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath. One shared memory serves instruction fetch and data access; one shared ALU serves PC increment, branch target, address calculation and execution.
- Decodes the opcode held in the instruction register and drives every datapath enable and mux select.
- Inserts wait states on a memory-ready handshake, with a timeout guard.
- Replaces the single-cycle control unit when the processor is built in multicycle form.

Parameters:
- MEM_TIMEOUT, default 15: consecutive MemReady-low cycles tolerated in a memory state before abort.
- CNT_WIDTH, default 4: width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- OP  input  6  opcode from IR[31:26], stable from the cycle after FETCH
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory completes the current access this cycle
- PCEn  output  1  PC register load enable; PCWrite OR qualified branch
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  1  write register select: 0 = rt, 1 = rd
- MemtoReg  output  1  write-back select: 0 = ALUOut, 1 = MDR
- RegWrite  output  1  register file write
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = rs
- ALUSrcB  output  2  ALU B select: 00 = rt, 01 = 4, 10 = extended imm, 11 = signext imm<<2
- ZeroExt  output  1  immediate extender zero-extends instead of sign-extending
- ALUOp  output  3  000 add, 001 sub, 010 or, 011 and, 100 lui, 111 use funct
- PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
- InstrDone  output  1  one-cycle pulse in the final cycle of each instruction
- IllegalOp  output  1  one-cycle pulse on an unsupported opcode
- MemError  output  1  one-cycle pulse on a memory timeout
- State  output  4  current state, for debug

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, MEM_ADR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5, R_EXE = 6, R_WB = 7, BRANCH = 8, JUMP = 9, I_EXE = 10, I_WB = 11.
- Reset: while reset is high, all strobes and enables are 0 (PCEn, MemRead, MemWrite, IRWrite, RegWrite, all pulses). State becomes FETCH at the next edge and the wait counter clears. Reset mid-instruction abandons it with no further writes.
- Outputs decode from State only, except PCEn, IRWrite and the done/error pulses, which may also depend on MemReady and Zero. Every output not listed for a state is 0.
- FETCH: IorD = 0, MemRead = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 000, PCSource = 00.
  - IRWrite = PCEn = MemReady.
  - MemReady = 1 → go to DECODE; otherwise stay in FETCH.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 000 (branch target latched into ALUOut). Next state by OP:
  - 0x00 → R_EXE
  - 0x23 (lw) or 0x2B (sw) → MEM_ADR
  - 0x04 (beq) or 0x05 (bne) → BRANCH
  - 0x02 (j) → JUMP
  - 0x08 (addi), 0x0C (andi), 0x0D (ori), 0x0F (lui) → I_EXE
  - any other opcode → pulse IllegalOp and InstrDone, then FETCH.
- MEM_ADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 000. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IorD = 1, MemRead = 1. Go to MEM_WB when MemReady = 1.
- MEM_WB: RegDst = 0, MemtoReg = 1, RegWrite = 1, InstrDone = 1. Go to FETCH.
- MEM_WR: IorD = 1, MemWrite = 1. When MemReady = 1, pulse InstrDone and go to FETCH.
- R_EXE: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 111.
- R_WB: RegDst = 1, RegWrite = 1, InstrDone = 1.
- I_EXE: ALUSrcA = 1, ALUSrcB = 10.
  - ZeroExt = 1 for andi and ori.
  - ALUOp: addi = 000, andi = 011, ori = 010, lui = 100.
- I_WB: RegDst = 0, RegWrite = 1, InstrDone = 1.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 001, PCSource = 01.
  - PCEn = Zero for beq, ~Zero for bne.
  - InstrDone = 1, then FETCH.
- JUMP: PCSource = 10, PCEn = 1, InstrDone = 1, then FETCH.
- Latency with MemReady tied high:
  - R-type and I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq, bne, j: 3 cycles
  - each MemReady-low cycle adds one cycle.
- Wait counter:
  - Increments on each MemReady-low cycle in FETCH, MEM_RD or MEM_WR.
  - Clears on any state change or on MemReady = 1.
  - If MemReady is still 0 when the counter equals MEM_TIMEOUT: pulse MemError, go to FETCH with no IRWrite, PCEn, RegWrite or MemWrite. In FETCH this retries the same PC.
- MemReady = 1 in the timeout cycle: the access completes normally and MemError stays 0.

Test Plan:
- reset held 3 cycles, then released → State = 0 and all strobes 0 during reset; first FETCH with MemReady = 1 gives IRWrite = PCEn = 1 one cycle after release.
- MemReady = 1, OP sequence 0x00, 0x23, 0x2B, 0x08, 0x0D → InstrDone pulses at cycles 4, 9, 13, 17, 21; RegWrite = 1 only in R_WB, MEM_WB and I_WB; ZeroExt = 1 only in the ori I_EXE cycle.
- beq (0x04) with Zero = 1 → PCEn = 1, PCSource = 01 in BRANCH; bne (0x05) with Zero = 1 → PCEn = 0; j (0x02) → PCEn = 1, PCSource = 10.
- lw with MemReady low 3 cycles in MEM_RD → MEM_RD held 4 cycles, MEM_WB follows, lw total 8 cycles.
- MemReady held low in FETCH → MemError pulses on the 16th cycle, no IRWrite or PCEn, FETCH re-entered; MemReady high on the 16th cycle instead → normal fetch, no MemError.
- OP = 0x3F → IllegalOp and InstrDone pulse in DECODE, no writes; reset asserted in MEM_WR with MemReady = 0 → MemWrite = 0 from the reset cycle, State = FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS datapath.
// One shared memory and one shared ALU are sequenced across several cycles.
// Memory states stretch on MemReady, and a wait counter aborts to FETCH on timeout.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_WIDTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ZeroExt,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       InstrDone,
    output logic       IllegalOp,
    output logic       MemError,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_ADR = 4'd2,
        MEM_RD  = 4'd3,
        MEM_WB  = 4'd4,
        MEM_WR  = 4'd5,
        R_EXE   = 4'd6,
        R_WB    = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        I_EXE   = 4'd10,
        I_WB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 mem_wait;
    logic                 timeout;
    logic                 illegal;

    // Wait detection in memory states and the timeout guard on the wait counter
    always_comb begin
        mem_wait = 1'b0;
        if ((state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR)) begin
            mem_wait = ~MemReady;
        end
        timeout = mem_wait && (cnt_q == CNT_WIDTH'(MEM_TIMEOUT));
        cnt_d   = '0;
        if (mem_wait && !timeout) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Opcode legality as seen in DECODE
    always_comb begin
        illegal = 1'b1;
        case (OP)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: illegal = 1'b0;
            default:                                illegal = 1'b1;
        endcase
    end

    // Next-state selection; a timeout overrides everything and returns to FETCH
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (MemReady) state_d = DECODE;
            DECODE: begin
                case (OP)
                    OP_RTYPE:                          state_d = R_EXE;
                    OP_LW, OP_SW:                      state_d = MEM_ADR;
                    OP_BEQ, OP_BNE:                    state_d = BRANCH;
                    OP_J:                              state_d = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state_d = I_EXE;
                    default:                           state_d = FETCH;
                endcase
            end
            MEM_ADR: state_d = (OP == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:  if (MemReady) state_d = MEM_WB;
            MEM_WR:  if (MemReady) state_d = FETCH;
            R_EXE:   state_d = R_WB;
            I_EXE:   state_d = I_WB;
            default: state_d = FETCH;
        endcase
        if (timeout) begin
            state_d = FETCH;
        end
    end

    // Datapath controls decoded from the current state; strobes are forced low in reset
    always_comb begin
        PCEn      = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ZeroExt   = 1'b0;
        ALUOp     = 3'b000;
        PCSource  = 2'b00;
        InstrDone = 1'b0;
        IllegalOp = 1'b0;
        MemError  = timeout;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCEn    = MemReady;
            end
            DECODE: begin
                ALUSrcB   = 2'b11;
                IllegalOp = illegal;
                InstrDone = illegal;
            end
            MEM_ADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            MEM_WB: begin
                MemtoReg  = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            MEM_WR: begin
                IorD      = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = MemReady;
            end
            R_EXE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b111;
            end
            R_WB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            I_EXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ZeroExt = (OP == OP_ANDI) || (OP == OP_ORI);
                case (OP)
                    OP_ANDI: ALUOp = 3'b011;
                    OP_ORI:  ALUOp = 3'b010;
                    OP_LUI:  ALUOp = 3'b100;
                    default: ALUOp = 3'b000;
                endcase
            end
            I_WB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 3'b001;
                PCSource  = 2'b01;
                PCEn      = (OP == OP_BNE) ? ~Zero : Zero;
                InstrDone = 1'b1;
            end
            JUMP: begin
                PCSource  = 2'b10;
                PCEn      = 1'b1;
                InstrDone = 1'b1;
            end
            default: begin
                PCEn = 1'b0;
            end
        endcase
        if (reset) begin
            PCEn      = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            InstrDone = 1'b0;
            IllegalOp = 1'b0;
            MemError  = 1'b0;
        end
    end

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed stimulus against an instruction-level model
// (per-opcode state plans plus a wait tally), checked every cycle, with literal
// latency and pulse-position expectations.
module tb_multicycle_control;

    localparam int MEM_TIMEOUT = 15;
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADR = 2, S_MEM_RD = 3, S_MEM_WB = 4;
    localparam int S_MEM_WR = 5, S_R_EXE = 6, S_R_WB = 7, S_BRANCH = 8, S_JUMP = 9;
    localparam int S_I_EXE = 10, S_I_WB = 11;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, ior_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, zero_ext, instr_done, illegal_op, mem_error;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    multicycle_control #(.MEM_TIMEOUT(15), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .OP(op), .Zero(zero), .MemReady(mem_ready),
        .PCEn(pc_en), .IorD(ior_d), .MemRead(mem_read), .MemWrite(mem_write),
        .IRWrite(ir_write), .RegDst(reg_dst), .MemtoReg(mem_to_reg), .RegWrite(reg_write),
        .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ZeroExt(zero_ext), .ALUOp(alu_op),
        .PCSource(pc_source), .InstrDone(instr_done), .IllegalOp(illegal_op),
        .MemError(mem_error), .State(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    // model state: current step, remaining plan of the instruction, wait tally
    int  m_cur = 0;
    int  m_wait = 0;
    int  m_plan[$];
    int  cyc = 0;
    int  done_q[$];
    int  zext_cnt = 0;
    bit  first_ok = 1'b0;

    logic       e_pcen, e_iord, e_mem_read, e_mem_write, e_ir_write, e_reg_dst, e_mem_to_reg;
    logic       e_reg_write, e_alu_src_a, e_zero_ext, e_done, e_ill, e_err;
    logic [1:0] e_alu_src_b, e_pc_source;
    logic [2:0] e_alu_op;

    int         r_len, r_rd, r_err, r_ill;
    logic       r_pcen;
    logic [1:0] r_pcsrc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_mem(input int s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    function automatic bit legal(input logic [5:0] o);
        return o inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    endfunction

    // states an instruction walks through after DECODE
    task automatic plan_for(input logic [5:0] o);
        m_plan.delete();
        case (o)
            6'h00:                      begin m_plan.push_back(S_R_EXE); m_plan.push_back(S_R_WB); end
            6'h23:                      begin m_plan.push_back(S_MEM_ADR); m_plan.push_back(S_MEM_RD);
                                              m_plan.push_back(S_MEM_WB); end
            6'h2B:                      begin m_plan.push_back(S_MEM_ADR); m_plan.push_back(S_MEM_WR); end
            6'h04, 6'h05:               m_plan.push_back(S_BRANCH);
            6'h02:                      m_plan.push_back(S_JUMP);
            6'h08, 6'h0C, 6'h0D, 6'h0F: begin m_plan.push_back(S_I_EXE); m_plan.push_back(S_I_WB); end
            default:                    m_plan.delete();
        endcase
    endtask

    task automatic model_outputs();
        {e_pcen, e_iord, e_mem_read, e_mem_write, e_ir_write, e_reg_dst, e_mem_to_reg} = '0;
        {e_reg_write, e_alu_src_a, e_zero_ext, e_done, e_ill, e_err} = '0;
        e_alu_src_b = 2'b00; e_pc_source = 2'b00; e_alu_op = 3'b000;
        case (m_cur)
            S_FETCH:   begin e_mem_read = 1; e_alu_src_b = 2'b01; e_ir_write = mem_ready; e_pcen = mem_ready; end
            S_DECODE:  begin e_alu_src_b = 2'b11; e_ill = !legal(op); e_done = !legal(op); end
            S_MEM_ADR: begin e_alu_src_a = 1; e_alu_src_b = 2'b10; end
            S_MEM_RD:  begin e_iord = 1; e_mem_read = 1; end
            S_MEM_WB:  begin e_mem_to_reg = 1; e_reg_write = 1; e_done = 1; end
            S_MEM_WR:  begin e_iord = 1; e_mem_write = 1; e_done = mem_ready; end
            S_R_EXE:   begin e_alu_src_a = 1; e_alu_op = 3'b111; end
            S_R_WB:    begin e_reg_dst = 1; e_reg_write = 1; e_done = 1; end
            S_I_EXE: begin
                e_alu_src_a = 1; e_alu_src_b = 2'b10;
                e_zero_ext = (op == 6'h0C) || (op == 6'h0D);
                e_alu_op = (op == 6'h0C) ? 3'b011 : (op == 6'h0D) ? 3'b010 : (op == 6'h0F) ? 3'b100 : 3'b000;
            end
            S_I_WB:    begin e_reg_write = 1; e_done = 1; end
            S_BRANCH: begin
                e_alu_src_a = 1; e_alu_op = 3'b001; e_pc_source = 2'b01; e_done = 1;
                e_pcen = (op == 6'h04) ? zero : !zero;
            end
            S_JUMP:    begin e_pc_source = 2'b10; e_pcen = 1; e_done = 1; end
            default:   e_done = 0;
        endcase
        if (is_mem(m_cur) && !mem_ready && (m_wait == MEM_TIMEOUT)) e_err = 1;
        if (reset) begin
            {e_pcen, e_mem_read, e_mem_write, e_ir_write, e_reg_write, e_done, e_ill, e_err} = '0;
        end
    endtask

    task automatic model_advance();
        if (reset) begin
            m_cur = S_FETCH; m_wait = 0; m_plan.delete();
        end else if (is_mem(m_cur) && !mem_ready) begin
            if (m_wait == MEM_TIMEOUT) begin
                m_cur = S_FETCH; m_wait = 0; m_plan.delete();
            end else begin
                m_wait++;
            end
        end else begin
            m_wait = 0;
            if (m_cur == S_FETCH) begin
                m_cur = S_DECODE;
            end else begin
                if (m_cur == S_DECODE) plan_for(op);
                if (m_plan.size() == 0) m_cur = S_FETCH;
                else m_cur = m_plan.pop_front();
            end
        end
    endtask

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            model_outputs();
            chk("State", 32'(state), 32'(m_cur));
            chk("PCEn", 32'(pc_en), 32'(e_pcen));
            chk("IorD", 32'(ior_d), 32'(e_iord));
            chk("MemRead", 32'(mem_read), 32'(e_mem_read));
            chk("MemWrite", 32'(mem_write), 32'(e_mem_write));
            chk("IRWrite", 32'(ir_write), 32'(e_ir_write));
            chk("RegDst", 32'(reg_dst), 32'(e_reg_dst));
            chk("MemtoReg", 32'(mem_to_reg), 32'(e_mem_to_reg));
            chk("RegWrite", 32'(reg_write), 32'(e_reg_write));
            chk("ALUSrcA", 32'(alu_src_a), 32'(e_alu_src_a));
            chk("ALUSrcB", 32'(alu_src_b), 32'(e_alu_src_b));
            chk("ZeroExt", 32'(zero_ext), 32'(e_zero_ext));
            chk("ALUOp", 32'(alu_op), 32'(e_alu_op));
            chk("PCSource", 32'(pc_source), 32'(e_pc_source));
            chk("InstrDone", 32'(instr_done), 32'(e_done));
            chk("IllegalOp", 32'(illegal_op), 32'(e_ill));
            chk("MemError", 32'(mem_error), 32'(e_err));
            if (reset) cyc = 0;
            else cyc++;
            if (!reset && (instr_done === 1'b1)) done_q.push_back(cyc);
            if (zero_ext === 1'b1) zext_cnt++;
            if (cyc == 1) first_ok = (ir_write === 1'b1) && (pc_en === 1'b1);
            model_advance();
        end
    end

    // one instruction from FETCH to its InstrDone; MemReady/Zero are random where irrelevant
    task automatic run_instr(input logic [5:0] o, input logic z, input int fetch_waits, input int mem_waits);
        int  fw;
        int  mw;
        bit  done;
        fw = fetch_waits; mw = mem_waits; done = 0;
        r_len = 0; r_rd = 0; r_err = 0; r_ill = 0; r_pcen = 0; r_pcsrc = 0;
        op = o;
        for (int k = 0; k < 64; k++) begin
            if (m_cur == S_FETCH) begin
                if (fw > 0) begin mem_ready = 0; fw--; end else mem_ready = 1;
            end else if ((m_cur == S_MEM_RD) || (m_cur == S_MEM_WR)) begin
                if (mw > 0) begin mem_ready = 0; mw--; end else mem_ready = 1;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            zero = (m_cur == S_BRANCH) ? z : 1'($urandom_range(0, 1));
            @(negedge clk);
            r_len++;
            if (state == 4'd3) r_rd++;
            if (mem_error === 1'b1) r_err++;
            if (illegal_op === 1'b1) r_ill++;
            if (instr_done === 1'b1) begin
                r_pcen = pc_en; r_pcsrc = pc_source; done = 1;
            end
            @(posedge clk); #1;
            if (done) break;
        end
        if (!done) chk("instr_bound", 0, 1);
    endtask

    int exp_done[5] = '{4, 9, 13, 17, 21};
    int first_err;
    int err_cnt;
    int bad_wr;

    initial begin
        reset = 1; op = 6'h00; zero = 0; mem_ready = 1;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        zext_cnt = 0; done_q.delete();
        reset = 0;

        // R, lw, sw, addi, ori back to back with MemReady high
        run_instr(6'h00, 0, 0, 0);
        run_instr(6'h23, 0, 0, 0);
        run_instr(6'h2B, 0, 0, 0);
        run_instr(6'h08, 0, 0, 0);
        run_instr(6'h0D, 0, 0, 0);
        chk("first_fetch_irwrite_pcen", 32'(first_ok), 1);
        chk("done_count", done_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < done_q.size()) chk("done_cycle", done_q[i], exp_done[i]);
        end
        chk("zeroext_cycles", zext_cnt, 1);

        // branches and jump
        run_instr(6'h04, 1, 0, 0);
        chk("beq_len", r_len, 3); chk("beq_pcen", 32'(r_pcen), 1); chk("beq_pcsrc", 32'(r_pcsrc), 1);
        run_instr(6'h05, 1, 0, 0);
        chk("bne_len", r_len, 3); chk("bne_pcen", 32'(r_pcen), 0); chk("bne_pcsrc", 32'(r_pcsrc), 1);
        run_instr(6'h05, 0, 0, 0);
        chk("bne_taken_pcen", 32'(r_pcen), 1);
        run_instr(6'h04, 0, 0, 0);
        chk("beq_nt_pcen", 32'(r_pcen), 0);
        run_instr(6'h02, 0, 0, 0);
        chk("j_len", r_len, 3); chk("j_pcen", 32'(r_pcen), 1); chk("j_pcsrc", 32'(r_pcsrc), 2);

        // memory wait states and remaining I-type ops
        run_instr(6'h23, 0, 0, 3);
        chk("lw_wait_len", r_len, 8); chk("lw_memrd_cycles", r_rd, 4);
        run_instr(6'h2B, 0, 0, 2);
        chk("sw_wait_len", r_len, 6);
        run_instr(6'h0F, 0, 0, 0);
        chk("lui_len", r_len, 4);
        run_instr(6'h0C, 0, 1, 0);
        chk("andi_len", r_len, 5);

        // fetch timeout: MemReady low for 16 cycles
        op = 6'h00; first_err = 0; err_cnt = 0; bad_wr = 0;
        for (int k = 1; k <= 16; k++) begin
            mem_ready = 0;
            @(negedge clk);
            if (mem_error === 1'b1) begin
                err_cnt++;
                if (first_err == 0) first_err = k;
            end
            if ((ir_write !== 1'b0) || (pc_en !== 1'b0)) bad_wr++;
            @(posedge clk); #1;
        end
        chk("timeout_cycle", first_err, 16);
        chk("timeout_pulses", err_cnt, 1);
        chk("timeout_no_fetch_write", bad_wr, 0);

        // MemReady arriving in the timeout cycle completes normally
        run_instr(6'h00, 0, 15, 0);
        chk("late_ready_len", r_len, 19); chk("late_ready_noerr", r_err, 0);

        // unsupported opcode
        run_instr(6'h3F, 0, 0, 0);
        chk("illegal_len", r_len, 2); chk("illegal_pulses", r_ill, 1);

        // reset while a store waits in MEM_WR
        op = 6'h2B; zero = 0; mem_ready = 1;
        repeat (3) begin @(negedge clk); @(posedge clk); #1; end
        mem_ready = 0;
        @(negedge clk);
        chk("memwr_waiting", 32'(mem_write), 1);
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        chk("memwr_reset_cycle", 32'(mem_write), 0);
        chk("state_reset_cycle", 32'(state), 5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("state_after_reset", 32'(state), 0);
        chk("memwr_after_reset", 32'(mem_write), 0);
        @(posedge clk); #1;
        reset = 0; mem_ready = 1;
        run_instr(6'h0D, 0, 0, 0);
        chk("recover_len", r_len, 4);

        @(posedge clk); #1;
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
